// File: rtl/bus_memtest.sv
// Bus memory self-test initiator: writes seed+n over an address window,
// reads it back, and stops at the first mismatch, bus error or timeout.
module bus_memtest #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] BASE      = 32'h0,
    parameter int unsigned COUNT     = 32'h400,
    parameter logic [31:0] ADDR_STEP = 32'd4,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_seed,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic             o_bus_error,
    output logic [31:0]      o_fail_address,
    output logic [WIDTH-1:0] o_fail_expected,
    output logic [WIDTH-1:0] o_fail_actual,
    output logic             o_request,
    output logic             o_rw,
    output logic [31:0]      o_address,
    output logic [WIDTH-1:0] o_wdata,
    input  logic [WIDTH-1:0] i_rdata,
    input  logic             i_ready,
    input  logic             i_valid
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_GAP,
        READ,
        READ_GAP,
        DONE
    } state_t;

    localparam logic [31:0] LAST   = 32'(COUNT - 1);
    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    logic [31:0]      index;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] next_pattern;
    logic [TW-1:0]    wait_count;

    logic handshake;
    logic last;
    logic bus_fault;
    logic data_fault;
    logic timed_out;
    logic all_done;

    always_comb begin
        handshake    = (state == WRITE) || (state == READ);
        last         = (index == LAST);
        next_pattern = pattern + WIDTH'(1);
        bus_fault    = handshake && i_ready && !i_valid;
        data_fault   = (state == READ) && i_ready && i_valid
                       && (i_rdata != pattern);
        timed_out    = handshake && !i_ready && (wait_count == T_LAST);
        all_done     = (state == READ_GAP) && last;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            index           <= '0;
            seed            <= '0;
            pattern         <= '0;
            wait_count      <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_timeout       <= 1'b0;
            o_bus_error     <= 1'b0;
            o_fail_address  <= '0;
            o_fail_expected <= '0;
            o_fail_actual   <= '0;
            o_request       <= 1'b0;
            o_rw            <= 1'b0;
            o_address       <= '0;
            o_wdata         <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        state           <= WRITE;
                        seed            <= i_seed;
                        pattern         <= i_seed;
                        index           <= '0;
                        wait_count      <= '0;
                        o_busy          <= 1'b1;
                        o_done          <= 1'b0;
                        o_pass          <= 1'b0;
                        o_timeout       <= 1'b0;
                        o_bus_error     <= 1'b0;
                        o_fail_address  <= '0;
                        o_fail_expected <= '0;
                        o_fail_actual   <= '0;
                        o_request       <= 1'b1;
                        o_rw            <= 1'b1;
                        o_address       <= BASE;
                        o_wdata         <= i_seed;
                    end
                end
                WRITE: begin
                    if (i_ready) begin
                        o_request <= 1'b0;
                        state     <= WRITE_GAP;
                    end else begin
                        wait_count <= wait_count + TW'(1);
                    end
                end
                WRITE_GAP: begin
                    o_request  <= 1'b1;
                    wait_count <= '0;
                    if (last) begin
                        state     <= READ;
                        index     <= '0;
                        pattern   <= seed;
                        o_rw      <= 1'b0;
                        o_address <= BASE;
                        o_wdata   <= '0;
                    end else begin
                        state     <= WRITE;
                        index     <= index + 32'd1;
                        pattern   <= next_pattern;
                        o_address <= o_address + ADDR_STEP;
                        o_wdata   <= next_pattern;
                    end
                end
                READ: begin
                    if (i_ready) begin
                        o_request <= 1'b0;
                        state     <= READ_GAP;
                    end else begin
                        wait_count <= wait_count + TW'(1);
                    end
                end
                READ_GAP: begin
                    state      <= READ;
                    o_request  <= 1'b1;
                    wait_count <= '0;
                    index      <= index + 32'd1;
                    pattern    <= next_pattern;
                    o_address  <= o_address + ADDR_STEP;
                end
                default: begin
                    state     <= IDLE;
                    o_request <= 1'b0;
                end
            endcase

            // Every way of ending a run funnels through here and wins over
            // the normal progression chosen above.
            if (bus_fault || data_fault || timed_out || all_done) begin
                state       <= DONE;
                o_request   <= 1'b0;
                o_busy      <= 1'b0;
                o_done      <= 1'b1;
                o_pass      <= all_done;
                o_bus_error <= bus_fault;
                o_timeout   <= timed_out;
                if (!all_done) begin
                    o_fail_address <= o_address;
                end
                if (data_fault) begin
                    o_fail_expected <= pattern;
                    o_fail_actual   <= i_rdata;
                end
            end
        end
    end

endmodule
